// File: rtl/booth_dot_seq.sv
// Operand sequencer and signed product accumulator around a 4-bit sequential Booth multiplier.
// Issues one multiply per (x, y) pair and presents the accumulated dot product on a valid/ready port.
module booth_dot_seq #(
    parameter int ACC_W   = 12,
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_x,
    input  logic [3:0]       in_y,
    input  logic             in_last,
    output logic             mul_start,
    output logic [3:0]       mul_x,
    output logic [3:0]       mul_y,
    input  logic             mul_valid,
    input  logic [7:0]       mul_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [3:0]       x_q, x_d;
    logic [3:0]       y_q, y_d;
    logic             last_q, last_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    logic [ACC_W-1:0] z_ext;
    logic [ACC_W-1:0] sum;

    assign z_ext = ACC_W'($signed(mul_z));
    assign sum   = acc_q + z_ext;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        x_d     = x_q;
        y_d     = y_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    last_d  = in_last;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                // A result arriving on the timeout cycle still counts.
                if (mul_valid) begin
                    acc_d   = sum;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    ovf_d   = ovf_q | ((acc_q[ACC_W-1] == z_ext[ACC_W-1]) &&
                                       (sum[ACC_W-1] != acc_q[ACC_W-1]));
                    state_d = last_q ? S_DONE : S_IDLE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            last_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            x_q     <= x_d;
            y_q     <= y_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign mul_start = (state_q == S_ISSUE);
    assign mul_x     = x_q;
    assign mul_y     = y_q;
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_booth_dot_seq.sv
// Directed bench for booth_dot_seq with a behavioural 5-cycle multiplier model.
module tb_booth_dot_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_x;
    logic [3:0]  in_y;
    logic        in_last;
    logic        mul_start;
    logic [3:0]  mul_x;
    logic [3:0]  mul_y;
    logic        mul_valid;
    logic [7:0]  mul_z;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [5:0]  out_count;
    logic        out_ovf;
    logic        out_err;

    booth_dot_seq #(.ACC_W(12), .CNT_W(6), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
        .mul_valid(mul_valid), .mul_z(mul_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count),
        .out_ovf(out_ovf), .out_err(out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiplier model: valid pulse five edges after the start edge.
    logic       mv;
    logic       mul_en;
    logic       spur;
    int         mcnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mv    <= 1'b0;
            mcnt  <= 0;
            mul_z <= 8'd0;
        end else begin
            mv <= 1'b0;
            if (mul_start) begin
                mcnt  <= 4;
                mul_z <= 8'($signed(mul_x) * $signed(mul_y));
            end else if (mcnt == 1) begin
                mcnt <= 0;
                mv   <= 1'b1;
            end else if (mcnt > 1) begin
                mcnt <= mcnt - 1;
            end
        end
    end
    assign mul_valid = (mv & mul_en) | spur;

    int n_vec;
    int n_miss;

    typedef struct {
        logic signed [3:0] x;
        logic signed [3:0] y;
        bit                last;
        int                sum;
        int                cnt;
    } elem_t;
    elem_t tbl[8];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    function automatic int w12(input int v);
        logic [11:0] t;
        t = v[11:0];
        return int'($signed(t));
    endfunction

    task automatic send_pair(input logic signed [3:0] x, input logic signed [3:0] y,
                             input bit last, input int esum, input int ecnt);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        if (in_ready !== 1'b1) chk("in_ready_wait", int'(in_ready), 1);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_last = last;
        step();
        in_valid = 1'b0;
        in_x = ~x;
        in_y = ~y;
        in_last = ~last;
        chk("start_t1", int'(mul_start), 1);
        chk("ready_t1", int'(in_ready), 0);
        for (int c = 2; c <= 6; c++) begin
            step();
            chk("start_off", int'(mul_start), 0);
            chk("ready_busy", int'(in_ready), 0);
            chk("hold_x", int'($signed(mul_x)), int'(x));
            chk("hold_y", int'($signed(mul_y)), int'(y));
        end
        step();
        chk("ready_t7", int'(in_ready), last ? 0 : 1);
        chk("valid_t7", int'(out_valid), last ? 1 : 0);
        chk("sum_t7", int'($signed(out_sum)), esum);
        chk("count_t7", int'(out_count), ecnt);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("rel_ready", int'(in_ready), 1);
        chk("rel_valid", int'(out_valid), 0);
        chk("rel_sum", int'($signed(out_sum)), 0);
        chk("rel_count", int'(out_count), 0);
        chk("rel_ovf", int'(out_ovf), 0);
        chk("rel_err", int'(out_err), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_x = 4'd0;
        in_y = 4'd0;
        in_last = 1'b0;
        out_ready = 1'b0;
        mul_en = 1'b1;
        spur = 1'b0;

        tbl[0] = '{4'sd3,  -4'sd2, 1'b1, -6,  1};
        tbl[1] = '{4'sd7,   4'sd7, 1'b0, 49,  1};
        tbl[2] = '{-4'sd3,  4'sd5, 1'b0, 34,  2};
        tbl[3] = '{4'sd2,  -4'sd8, 1'b1, 18,  3};
        tbl[4] = '{-4'sd8,  4'sd7, 1'b1, -56, 1};
        tbl[5] = '{-4'sd1, -4'sd1, 1'b0, 1,   1};
        tbl[6] = '{4'sd5,  -4'sd3, 1'b1, -14, 2};
        tbl[7] = '{-4'sd7, -4'sd7, 1'b1, 49,  1};

        step();
        step();
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_start", int'(mul_start), 0);
        chk("rst_mulx", int'(mul_x), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sum", int'(out_sum), 0);
        chk("rst_count", int'(out_count), 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            send_pair(tbl[i].x, tbl[i].y, tbl[i].last, tbl[i].sum, tbl[i].cnt);
            if (tbl[i].last) begin
                chk("vec_ovf", int'(out_ovf), 0);
                chk("vec_err", int'(out_err), 0);
                release_out();
            end
        end

        // Backpressure: result held for 10 cycles with stray in_valid ignored.
        send_pair(-4'sd5, 4'sd3, 1'b1, -15, 1);
        in_valid = 1'b1;
        in_x = 4'd1;
        in_y = 4'd1;
        in_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_sum", int'($signed(out_sum)), -15);
            chk("bp_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        release_out();
        send_pair(4'sd2, 4'sd2, 1'b1, 4, 1);
        release_out();

        // Overflow: 42 * 49 = 2058 wraps to -2038 in 12 bits.
        for (int i = 0; i < 42; i++) begin
            send_pair(4'sd7, 4'sd7, i == 41, w12((i + 1) * 49), i + 1);
        end
        chk("ovf_flag", int'(out_ovf), 1);
        chk("ovf_sum", int'($signed(out_sum)), -2038);
        chk("ovf_err", int'(out_err), 0);
        release_out();

        // Timeout: WAIT entered in T+2, DONE expected in T+17.
        mul_en = 1'b0;
        in_valid = 1'b1;
        in_x = 4'd2;
        in_y = 4'd3;
        in_last = 1'b1;
        step();
        in_valid = 1'b0;
        chk("tmo_start", int'(mul_start), 1);
        for (int c = 2; c <= 16; c++) begin
            step();
            chk("tmo_wait", int'(out_valid), 0);
        end
        step();
        chk("tmo_valid", int'(out_valid), 1);
        chk("tmo_err", int'(out_err), 1);
        chk("tmo_count", int'(out_count), 0);
        chk("tmo_sum", int'($signed(out_sum)), 0);
        mul_en = 1'b1;
        release_out();
        spur = 1'b1;
        step();
        spur = 1'b0;
        chk("spur_sum", int'($signed(out_sum)), 0);
        chk("spur_count", int'(out_count), 0);
        chk("spur_ready", int'(in_ready), 1);
        step();
        chk("spur_sum2", int'($signed(out_sum)), 0);

        // Reset in T+4 of a second element abandons the vector.
        send_pair(4'sd3, 4'sd3, 1'b0, 9, 1);
        in_valid = 1'b1;
        in_x = 4'd6;
        in_y = 4'd5;
        in_last = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        chk("mrst_ready", int'(in_ready), 1);
        chk("mrst_start", int'(mul_start), 0);
        chk("mrst_mulx", int'(mul_x), 0);
        chk("mrst_muly", int'(mul_y), 0);
        chk("mrst_valid", int'(out_valid), 0);
        chk("mrst_sum", int'(out_sum), 0);
        chk("mrst_count", int'(out_count), 0);
        chk("mrst_ovf", int'(out_ovf), 0);
        chk("mrst_err", int'(out_err), 0);
        step();
        rst = 1'b1;
        step();
        send_pair(4'sd4, 4'sd4, 1'b1, 16, 1);
        chk("post_rst_err", int'(out_err), 0);
        release_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
